// File: rtl/booth_bist_driver.sv
// booth_bist_driver: built-in self-test initiator for the 4x4 signed Booth
// multiplier. Issues LFSR operands, waits for the multiplier to finish,
// checks each product against a signed reference and counts failures.
// Define BIST_MISR_EN to compact every good product into an 8-bit MISR on sig.
module booth_bist_driver #(
    parameter int         NPAT    = 16,
    parameter logic [7:0] SEED    = 8'hA5,
    parameter int         TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic       start_o,
    input  logic       busy_i,
    input  logic [7:0] product_i,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_cnt,
    output logic [7:0] sig
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [7:0]        SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam int                WDOG_W    = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
    localparam logic [7:0]        LAST_PAT  = 8'(NPAT - 1);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, CHECK, FINISH
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [7:0]        r_lfsr;
    logic [7:0]        r_count;
    logic [7:0]        r_fail;
    logic [3:0]        r_a;
    logic [3:0]        r_b;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_timedOut;
    logic              r_done;
    logic              r_pass;
    logic              w_timeoutHit;
    logic              w_wdogExpired;
    logic              w_lastPat;
    logic              w_mismatch;
    logic [7:0]        w_lfsrNext;
    logic [7:0]        w_failNext;
    logic signed [7:0] w_aExt;
    logic signed [7:0] w_bExt;
    logic signed [7:0] w_expect;

    assign w_lfsrNext    = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_wdogExpired = (r_wdog >= WDOG_LAST);
    assign w_lastPat     = (r_count == LAST_PAT);

    // Reference product; a 4x4 signed product always fits in 8 bits.
    assign w_aExt     = {{4{r_a[3]}}, r_a};
    assign w_bExt     = {{4{r_b[3]}}, r_b};
    assign w_expect   = w_aExt * w_bExt;
    assign w_mismatch = (product_i != w_expect);

    // A timed-out pattern is always a failure; the counter saturates at 255.
    assign w_failNext = ((r_timedOut || w_mismatch) && (r_fail != 8'hFF)) ?
                        r_fail + 8'd1 : r_fail;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    // Next-state logic; completion takes priority over a coincident timeout.
    always_comb begin
        w_nextState  = r_state;
        w_timeoutHit = 1'b0;
        case (r_state)
            IDLE:      if (run) w_nextState = ISSUE;
            ISSUE:     w_nextState = WAIT_BUSY;
            WAIT_BUSY: begin
                if (busy_i) begin
                    w_nextState = WAIT_DONE;
                end else if (w_wdogExpired) begin
                    w_nextState  = CHECK;
                    w_timeoutHit = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!busy_i) begin
                    w_nextState = CHECK;
                end else if (w_wdogExpired) begin
                    w_nextState  = CHECK;
                    w_timeoutHit = 1'b1;
                end
            end
            CHECK:     w_nextState = w_lastPat ? FINISH : ISSUE;
            FINISH:    if (run) w_nextState = ISSUE;
            default:   w_nextState = IDLE;
        endcase
    end

    // Pattern datapath: operands, LFSR, counters, watchdog and result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr     <= SEED_EFF;
            r_count    <= 8'd0;
            r_fail     <= 8'd0;
            r_a        <= 4'd0;
            r_b        <= 4'd0;
            r_wdog     <= '0;
            r_timedOut <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, FINISH: begin
                    if (run) begin
                        r_lfsr  <= SEED_EFF;
                        r_a     <= SEED_EFF[7:4];
                        r_b     <= SEED_EFF[3:0];
                        r_count <= 8'd0;
                        r_fail  <= 8'd0;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_wdog     <= '0;
                    r_timedOut <= 1'b0;
                end
                WAIT_BUSY, WAIT_DONE: begin
                    if (!w_wdogExpired) r_wdog <= r_wdog + 1'b1;
                    r_timedOut <= w_timeoutHit;
                end
                CHECK: begin
                    r_fail  <= w_failNext;
                    r_lfsr  <= w_lfsrNext;
                    r_count <= r_count + 8'd1;
                    if (w_lastPat) begin
                        r_done <= 1'b1;
                        r_pass <= (w_failNext == 8'd0);
                    end else begin
                        r_a <= w_lfsrNext[7:4];
                        r_b <= w_lfsrNext[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BIST_MISR_EN
    logic [7:0] r_sig;

    // Signature register: compacts every non-timeout product of the run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= 8'd0;
        end else if (run && (r_state == IDLE || r_state == FINISH)) begin
            r_sig <= 8'd0;
        end else if (r_state == CHECK && !r_timedOut) begin
            r_sig <= {r_sig[6:0], r_sig[7] ^ r_sig[5] ^ r_sig[4] ^ r_sig[3]} ^ product_i;
        end
    end

    assign sig = r_sig;
`else
    assign sig = 8'h00;
`endif

    // start_o decodes straight from the state so reset removes it at once.
    assign start_o  = (r_state == ISSUE);
    assign a_o      = r_a;
    assign b_o      = r_b;
    assign done     = r_done;
    assign pass     = r_pass;
    assign fail_cnt = r_fail;

endmodule

// File: tb/tb_booth_bist_driver.sv
// tb_booth_bist_driver: directed bench for booth_bist_driver with a
// behavioural multiplier responder (ideal, single-fault and dead modes).
// Build with BIST_MISR_EN defined to also check the MISR signature.
module tb_booth_bist_driver;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic [3:0] a_o;
    logic [3:0] b_o;
    logic       start_o;
    logic       busy_i;
    logic [7:0] product_i;
    logic       done;
    logic       pass;
    logic [7:0] fail_cnt;
    logic [7:0] sig;

    int         vectors    = 0;
    int         miscompares = 0;
    int         respMode   = 0;
    int         patIdx     = 0;
    int         startCount = 0;
    int         wideStart  = 0;
    logic [7:0] firstProduct = 8'h00;

    booth_bist_driver #(.NPAT(16), .SEED(8'hA5), .TIMEOUT(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .a_o       (a_o),
        .b_o       (b_o),
        .start_o   (start_o),
        .busy_i    (busy_i),
        .product_i (product_i),
        .done      (done),
        .pass      (pass),
        .fail_cnt  (fail_cnt),
        .sig       (sig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsrStep(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] signedProd(input logic [3:0] a, input logic [3:0] b);
        logic signed [3:0] sa;
        logic signed [3:0] sb;
        int p;
        sa = a;
        sb = b;
        p  = sa * sb;
        return p[7:0];
    endfunction

    // Responder: busy one cycle after start_o for three cycles, then product.
    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        busy_i    = 1'b0;
        product_i = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (start_o === 1'b1 && respMode != 2) begin
                ra = a_o;
                rb = b_o;
                @(posedge clk); #1;
                busy_i = 1'b1;
                repeat (2) @(posedge clk);
                @(posedge clk); #1;
                busy_i    = 1'b0;
                product_i = signedProd(ra, rb) ^ ((respMode == 1 && patIdx == 3) ? 8'h01 : 8'h00);
                if (patIdx == 0) firstProduct = product_i;
                patIdx++;
            end
        end
    end

    // Start-pulse monitor: counts pulses and flags any wider than one cycle.
    initial begin
        logic prevStart;
        prevStart = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (start_o === 1'b1) begin
                if (prevStart) wideStart++;
                else           startCount++;
            end
            prevStart = start_o;
        end
    end

    task automatic applyStimulus();
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitStart(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (start_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        startCount = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            run = ~run;
        end
        vectors++; if (a_o !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_a: got %0h expected 0", a_o); end
        vectors++; if (b_o !== 4'h0) begin miscompares++; $display("[TB] FAIL rst_b: got %0h expected 0", b_o); end
        vectors++; if (start_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_start: got %0b expected 0", start_o); end
        vectors++; if (done !== 1'b0 || pass !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done_pass: got %0b%0b expected 00", done, pass); end
        vectors++; if (fail_cnt !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_fail_cnt: got %0h expected 0", fail_cnt); end
        vectors++; if (sig !== 8'h00) begin miscompares++; $display("[TB] FAIL rst_sig: got %0h expected 0", sig); end
        vectors++; if (startCount != 0) begin miscompares++; $display("[TB] FAIL rst_no_start: got %0d pulses expected 0", startCount); end
        run = 1'b0;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (startCount != 0 || start_o !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("[TB] FAIL idle_after_rst: got %0d pulses done %0b expected 0 pulses done 0", startCount, done);
        end
    endtask

    task automatic test_ideal();
        bit         ok;
        logic [7:0] v;
        logic [7:0] last;
        logic [7:0] misr;
        respMode = 0; patIdx = 0; startCount = 0; wideStart = 0;
        @(posedge clk); #1;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        vectors++; if (start_o !== 1'b1) begin miscompares++; $display("[TB] FAIL start_latency: got %0b expected 1", start_o); end
        vectors++; if (a_o !== 4'hA || b_o !== 4'h5) begin miscompares++; $display("[TB] FAIL first_operands: got %0h/%0h expected a/5", a_o, b_o); end
        @(posedge clk); #1;
        vectors++; if (start_o !== 1'b0) begin miscompares++; $display("[TB] FAIL start_width: got %0b expected 0", start_o); end
        waitDone(400, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL ideal_timeout: got done %0b expected 1", done); end
        vectors++; if (firstProduct !== 8'hE2) begin miscompares++; $display("[TB] FAIL first_product: got %0h expected e2", firstProduct); end
        vectors++; if (startCount != 16 || wideStart != 0) begin miscompares++; $display("[TB] FAIL ideal_starts: got %0d (wide %0d) expected 16 (wide 0)", startCount, wideStart); end
        vectors++; if (pass !== 1'b1 || fail_cnt !== 8'h00) begin miscompares++; $display("[TB] FAIL ideal_result: got pass %0b fail_cnt %0d expected 1/0", pass, fail_cnt); end
        v = 8'hA5; misr = 8'h00; last = 8'h00;
        for (int i = 0; i < 16; i++) begin
            misr = {misr[6:0], misr[7] ^ misr[5] ^ misr[4] ^ misr[3]} ^ signedProd(v[7:4], v[3:0]);
            last = v;
            v = lfsrStep(v);
        end
        vectors++; if ({a_o, b_o} !== last) begin miscompares++; $display("[TB] FAIL hold_last: got %0h expected %0h", {a_o, b_o}, last); end
`ifdef BIST_MISR_EN
        vectors++; if (sig !== misr) begin miscompares++; $display("[TB] FAIL misr_sig: got %0h expected %0h", sig, misr); end
`else
        vectors++; if (sig !== 8'h00) begin miscompares++; $display("[TB] FAIL sig_zero: got %0h expected 0 (misr would be %0h)", sig, misr); end
`endif
    endtask

    task automatic test_fault();
        bit ok;
        respMode = 1; patIdx = 0; startCount = 0; wideStart = 0;
        applyStimulus();
        vectors++; if (done !== 1'b0 || fail_cnt !== 8'h00) begin miscompares++; $display("[TB] FAIL restart_clear: got done %0b fail_cnt %0d expected 0/0", done, fail_cnt); end
        waitDone(400, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL fault_timeout: got done %0b expected 1", done); end
        vectors++; if (fail_cnt !== 8'd1 || pass !== 1'b0) begin miscompares++; $display("[TB] FAIL fault_result: got fail_cnt %0d pass %0b expected 1/0", fail_cnt, pass); end
        vectors++; if (startCount != 16) begin miscompares++; $display("[TB] FAIL fault_starts: got %0d expected 16", startCount); end
    endtask

    task automatic test_run_ignored();
        bit ok;
        respMode = 0; patIdx = 0; startCount = 0; wideStart = 0;
        applyStimulus();
        repeat (2) @(posedge clk);
        #1;
        run = 1'b1;
        @(posedge clk); #1;
        run = 1'b0;
        vectors++; if (start_o !== 1'b0) begin miscompares++; $display("[TB] FAIL run_in_wait: got start %0b expected 0", start_o); end
        waitDone(400, ok);
        vectors++; if (!ok || startCount != 16 || pass !== 1'b1) begin
            miscompares++; $display("[TB] FAIL run_ignored_result: got done %0b starts %0d pass %0b expected 1/16/1", ok, startCount, pass);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        respMode = 1; patIdx = 0;
        applyStimulus();
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (fail_cnt === 8'd1) begin ok = 1'b1; break; end
        end
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL mid_fail_seen: got %0d expected 1", fail_cnt); end
        waitStart(20, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL mid_start_seen: got %0b expected 1", start_o); end
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        vectors++; if (start_o !== 1'b0 || done !== 1'b0 || fail_cnt !== 8'h00 || a_o !== 4'h0) begin
            miscompares++; $display("[TB] FAIL async_reset: got start %0b done %0b fail_cnt %0d a %0h expected all 0", start_o, done, fail_cnt, a_o);
        end
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        respMode = 0; patIdx = 0;
        applyStimulus();
        vectors++; if (start_o !== 1'b1 || a_o !== 4'hA || b_o !== 4'h5) begin
            miscompares++; $display("[TB] FAIL replay_seed: got start %0b a/b %0h/%0h expected 1 a/5", start_o, a_o, b_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (start_o !== 1'b0) begin miscompares++; $display("[TB] FAIL async_start_drop: got %0b expected 0", start_o); end
        #2;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_dead();
        bit ok;
        respMode = 2; startCount = 0;
        applyStimulus();
        waitDone(1500, ok);
        vectors++; if (!ok) begin miscompares++; $display("[TB] FAIL dead_timeout: got done %0b expected 1", done); end
        vectors++; if (fail_cnt !== 8'd16 || pass !== 1'b0) begin miscompares++; $display("[TB] FAIL dead_result: got fail_cnt %0d pass %0b expected 16/0", fail_cnt, pass); end
        vectors++; if (startCount != 16 || sig !== 8'h00) begin miscompares++; $display("[TB] FAIL dead_starts_sig: got %0d/%0h expected 16/0", startCount, sig); end
    endtask

    // Test sequence.
    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        test_reset();
        test_ideal();
        test_fault();
        test_run_ignored();
        test_reset_mid();
        test_dead();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
